// File: rtl/uart_rx_fifo.sv
// Parametrised serial receiver (5-8 data bits, optional parity, 1-2 stop bits)
// feeding a small receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 921600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          perr,
    output logic                          ferr,
    output logic                          valid,
    input  logic                          ready,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned EW  = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_MID   = CW'((DIV - 1) / 2);
    localparam logic [CW-1:0] CNT_END   = CW'(DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    logic                 rx_meta_q, rxs_q;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 line_high_q, line_high_d;
    logic                 push;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic                 overrun_q, overrun_d;
    logic [AW:0]          count;
    logic                 full, pop, push_ok, ovr_set;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        line_high_d = line_high_q;
        push        = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A new frame needs a falling edge, not just a low line after a break.
                if (line_high_q && !rxs_q) begin
                    state_d     = StStart;
                    line_high_d = 1'b0;
                end else if (rxs_q) begin
                    line_high_d = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (cnt_q == CNT_END) begin
                    cnt_d         = '0;
                    data_d[bit_q] = rxs_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StPar: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StStop;
                    perr_d  = (PARITY == 1) ? ~(^data_q ^ rxs_q) : (^data_q ^ rxs_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CNT_END) begin
                    cnt_d  = '0;
                    ferr_d = ferr_q | ~rxs_q;
                    if (bit_q == LAST_STOP) begin
                        push        = 1'b1;
                        state_d     = StIdle;
                        line_high_d = rxs_q;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign push_entry = {perr_q, ferr_d, data_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            line_high_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            line_high_q <= line_high_d;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count     = wr_q - rd_q;
        valid     = (count != '0);
        full      = (count == FULL_CNT);
        pop       = valid & ready;
        push_ok   = push & (~full | pop);
        ovr_set   = push & full & ~pop;
        mem_d     = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = push_entry;
        end
        wr_d      = wr_q + {{AW{1'b0}}, push_ok};
        rd_d      = rd_q + {{AW{1'b0}}, pop};
        overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            overrun_q <= overrun_d;
        end
    end

    assign {perr, ferr, dout} = mem_q[rd_q[AW-1:0]];
    assign overrun            = overrun_q;
    assign fifo_count         = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three configurations (8N1, 8E1, 7O2) checked every
// cycle against a queue-based model, plus literal expectations per scenario.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_a    [3];
    logic       ready_a [3];
    logic       clr_a   [3];
    logic [7:0] dout_a  [3];
    logic       perr_a  [3];
    logic       ferr_a  [3];
    logic       valid_a [3];
    logic       ovr_a   [3];
    logic [2:0] cnt_a   [3];
    logic [6:0] dout_o;

    assign dout_a[2] = {1'b0, dout_o};

    uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut_n (
        .clk(clk), .rst(rst), .rx(rx_a[0]), .dout(dout_a[0]), .perr(perr_a[0]),
        .ferr(ferr_a[0]), .valid(valid_a[0]), .ready(ready_a[0]), .overrun(ovr_a[0]),
        .ovr_clr(clr_a[0]), .fifo_count(cnt_a[0]));

    uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut_e (
        .clk(clk), .rst(rst), .rx(rx_a[1]), .dout(dout_a[1]), .perr(perr_a[1]),
        .ferr(ferr_a[1]), .valid(valid_a[1]), .ready(ready_a[1]), .overrun(ovr_a[1]),
        .ovr_clr(clr_a[1]), .fifo_count(cnt_a[1]));

    uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(5000000), .DATA_BITS(7), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut_o (
        .clk(clk), .rst(rst), .rx(rx_a[2]), .dout(dout_o), .perr(perr_a[2]),
        .ferr(ferr_a[2]), .valid(valid_a[2]), .ready(ready_a[2]), .overrun(ovr_a[2]),
        .ovr_clr(clr_a[2]), .fifo_count(cnt_a[2]));

    // Model: entries are {perr, ferr, data}; pend_due is the clock edge that commits a push.
    logic [9:0] mq [3][$];
    logic       m_ovr    [3];
    int         pend_due [3];
    logic [9:0] pend_val [3];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                m_ovr[i]    = 1'b0;
                pend_due[i] = -1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), valid_a[i], mq[i].size() != 0);
            chk($sformatf("count%0d", i), cnt_a[i], mq[i].size());
            chk($sformatf("overrun%0d", i), ovr_a[i], m_ovr[i]);
            if (mq[i].size() != 0) begin
                chk($sformatf("dout%0d", i), dout_a[i], mq[i][0][7:0]);
                chk($sformatf("perr%0d", i), perr_a[i], mq[i][0][9]);
                chk($sformatf("ferr%0d", i), ferr_a[i], mq[i][0][8]);
            end
        end
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                logic set;
                set = 1'b0;
                if (mq[i].size() != 0 && ready_a[i]) void'(mq[i].pop_front());
                if (pend_due[i] == cyc + 1) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(pend_val[i]);
                    else set = 1'b1;
                end
                m_ovr[i] = set ? 1'b1 : (clr_a[i] ? 1'b0 : m_ovr[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame at 10 clocks per bit; stops after 'limit' bits to model an aborted frame.
    task automatic send(input int inst, input logic [7:0] data, input int nd, input int pmode,
                        input logic pbit, input logic [1:0] stops, input int nstop,
                        input int limit);
        logic       bits [12];
        logic [7:0] dm;
        int         nb;
        int         ones;
        logic       pe;
        logic       fe;
        bits[0] = 1'b0;
        ones    = 0;
        for (int k = 0; k < nd; k++) begin
            bits[1 + k] = data[k];
            ones += int'(data[k]);
        end
        nb = 1 + nd;
        if (pmode != 0) begin
            bits[nb] = pbit;
            nb++;
        end
        fe = 1'b0;
        for (int k = 0; k < nstop; k++) begin
            bits[nb] = stops[k];
            if (!stops[k]) fe = 1'b1;
            nb++;
        end
        if (pmode == 1) pe = ((ones + int'(pbit)) % 2) == 0;
        else if (pmode == 2) pe = ((ones + int'(pbit)) % 2) == 1;
        else pe = 1'b0;
        dm = data & 8'((1 << nd) - 1);
        pend_due[inst] = cyc + 1 + 10 * (nb - 1) + 7;
        pend_val[inst] = {pe, fe, dm};
        for (int k = 0; k < nb && k < limit; k++) begin
            rx_a[inst] = bits[k];
            tick(10);
        end
    endtask

    task automatic pop_chk(input int inst, input logic [7:0] d, input logic pe, input logic fe);
        chk("pop_valid", valid_a[inst], 1'b1);
        chk("pop_dout", dout_a[inst], d);
        chk("pop_perr", perr_a[inst], pe);
        chk("pop_ferr", ferr_a[inst], fe);
        ready_a[inst] = 1'b1;
        tick(1);
        ready_a[inst] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_a[i]    = 1'b1;
            ready_a[i] = 1'b0;
            clr_a[i]   = 1'b0;
        end
        #1 rst = 1'b1;
        tick(1);
        chk("rst_dout", dout_a[0], 8'h00);
        chk("rst_valid", valid_a[0], 1'b0);
        chk("rst_count", cnt_a[0], 3'd0);
        chk("rst_ovr", ovr_a[0], 1'b0);
        chk("rst_perr_ferr", {perr_a[0], ferr_a[0]}, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(5);

        // 8N1 single character
        send(0, 8'hA5, 8, 0, 1'b0, 2'b11, 1, 99);
        chk("t1_dout", dout_a[0], 8'hA5);
        chk("t1_flags", {perr_a[0], ferr_a[0]}, 2'b00);
        chk("t1_count", cnt_a[0], 3'd1);
        ready_a[0] = 1'b1;
        tick(1);
        ready_a[0] = 1'b0;
        chk("t1_valid_after_pop", valid_a[0], 1'b0);
        chk("t1_count_after_pop", cnt_a[0], 3'd0);

        // Even parity: wrong then right parity bit
        send(1, 8'h03, 8, 2, 1'b1, 2'b11, 1, 99);
        pop_chk(1, 8'h03, 1'b1, 1'b0);
        send(1, 8'h03, 8, 2, 1'b0, 2'b11, 1, 99);
        pop_chk(1, 8'h03, 1'b0, 1'b0);

        // Framing error, then a break that must yield exactly one entry
        send(0, 8'h55, 8, 0, 1'b0, 2'b00, 1, 99);
        rx_a[0] = 1'b1;
        tick(20);
        send(0, 8'h00, 8, 0, 1'b0, 2'b00, 1, 99);
        tick(200);
        chk("t3_break_count", cnt_a[0], 3'd2);
        rx_a[0] = 1'b1;
        tick(20);
        send(0, 8'h5A, 8, 0, 1'b0, 2'b11, 1, 99);
        chk("t3_count", cnt_a[0], 3'd3);
        pop_chk(0, 8'h55, 1'b0, 1'b1);
        pop_chk(0, 8'h00, 1'b0, 1'b1);
        pop_chk(0, 8'h5A, 1'b0, 1'b0);

        // Back-to-back frames into a full FIFO
        for (int d = 1; d <= 5; d++) send(0, 8'(d), 8, 0, 1'b0, 2'b11, 1, 99);
        chk("t4_count", cnt_a[0], 3'd4);
        chk("t4_ovr", ovr_a[0], 1'b1);
        chk("t4_head", dout_a[0], 8'h01);
        clr_a[0] = 1'b1;
        tick(1);
        clr_a[0] = 1'b0;
        chk("t4_ovr_clr", ovr_a[0], 1'b0);
        // Pop coinciding with the push edge on a full FIFO
        fork
            send(0, 8'h06, 8, 0, 1'b0, 2'b11, 1, 99);
            begin
                tick(1);
                while (cyc != pend_due[0] - 1) tick(1);
                ready_a[0] = 1'b1;
                tick(1);
                ready_a[0] = 1'b0;
            end
        join
        chk("t4_full_pp_count", cnt_a[0], 3'd4);
        chk("t4_full_pp_ovr", ovr_a[0], 1'b0);
        pop_chk(0, 8'h02, 1'b0, 1'b0);
        pop_chk(0, 8'h03, 1'b0, 1'b0);
        pop_chk(0, 8'h04, 1'b0, 1'b0);
        pop_chk(0, 8'h06, 1'b0, 1'b0);
        chk("t4_empty", cnt_a[0], 3'd0);

        // Start-bit glitch, then reset in the middle of a frame
        rx_a[0] = 1'b0;
        tick(3);
        rx_a[0] = 1'b1;
        tick(30);
        chk("t5_glitch_valid", valid_a[0], 1'b0);
        send(0, 8'h7E, 8, 0, 1'b0, 2'b11, 1, 5);
        rx_a[0] = 1'b1;
        rst = 1'b1;
        tick(2);
        chk("t5_rst_valid", valid_a[0], 1'b0);
        rst = 1'b0;
        tick(5);
        send(0, 8'h3C, 8, 0, 1'b0, 2'b11, 1, 99);
        pop_chk(0, 8'h3C, 1'b0, 1'b0);

        // 7 data bits, odd parity, two stop bits
        send(2, 8'h41, 7, 1, 1'b1, 2'b11, 2, 99);
        pop_chk(2, 8'h41, 1'b0, 1'b0);
        send(2, 8'h41, 7, 1, 1'b1, 2'b01, 2, 99);
        pop_chk(2, 8'h41, 1'b0, 1'b1);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
